// File: rtl/shape_sfr_pkg.sv
// Shared types for the shape-processor SFR driver: field positions, request record, FSM states.
// Latency: n/a (types only). Backpressure: n/a.
// Field helpers keep the write-data layout in one place.
package shape_sfr_pkg;

    localparam int SHAPE_MSB = 17;
    localparam int SHAPE_LSB = 16;
    localparam int OP_MSB    = 4;
    localparam int OP_LSB    = 0;

    typedef logic [1:0] shape_t;
    typedef logic [4:0] operation_t;

    typedef struct packed {
        shape_t     shape;
        operation_t operation;
    } shape_req_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_WAIT,
        ST_RESP
    } sfr_drv_state_e;

    function automatic logic [31:0] pack_req(input shape_req_t r);
        logic [31:0] d;
        d = '0;
        d[SHAPE_MSB:SHAPE_LSB] = r.shape;
        d[OP_MSB:OP_LSB]       = r.operation;
        return d;
    endfunction

endpackage

// File: rtl/shape_req_fifo.sv
// Synchronous request FIFO with registered full/empty flags and a head peek.
// Latency: pushed entry visible at the head one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
module shape_req_fifo
    import shape_sfr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  shape_req_t                 push_data,
    input  logic                       pop,
    output shape_req_t                 peek,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    shape_req_t        mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count_next;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign peek    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count - 1'b1;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/shape_sfr_driver.sv
// Issues one SFR write then one read-back per queued request and reports whether the SFR took the value.
// Latency: write N+1, read N+2, response N+3+RD_LATENCY after acceptance in cycle N.
// Backpressure: req_ready low while FIFO full; response held until rsp_ready.
module shape_sfr_driver
    import shape_sfr_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_shape,
    input  logic [4:0]  req_operation,
    output logic        write,
    output logic [31:0] write_data,
    output logic        read,
    input  logic [31:0] read_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_accepted,
    output logic [1:0]  rsp_shape,
    output logic [4:0]  rsp_operation,
    output logic        busy
);

    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int WCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    sfr_drv_state_e  state, state_next;
    shape_req_t      req_in;
    shape_req_t      head;
    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [WCW-1:0]  wait_cnt;
    logic            wait_last;
    shape_t          rd_shape;
    operation_t      rd_op;
    logic            unused_rd_bits;

    assign req_in    = '{shape: req_shape, operation: req_operation};
    assign req_ready = !fifo_full;
    assign push      = req_valid && req_ready;
    assign wait_last = (wait_cnt == '0);

    assign rd_shape       = read_data[SHAPE_MSB:SHAPE_LSB];
    assign rd_op          = read_data[OP_MSB:OP_LSB];
    assign unused_rd_bits = ^{read_data[31:SHAPE_MSB+1], read_data[SHAPE_LSB-1:OP_MSB+1]};

    shape_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (req_in),
        .pop       (pop),
        .peek      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            // Leaving IDLE on the push edge itself gives write in the very next cycle.
            ST_IDLE:  if (!fifo_empty || push) state_next = ST_WRITE;
            ST_WRITE: state_next = ST_READ;
            ST_READ:  state_next = ST_WAIT;
            ST_WAIT:  if (wait_last) state_next = ST_RESP;
            ST_RESP: begin
                if (rsp_ready) begin
                    pop        = 1'b1;
                    state_next = ((fifo_count > CW'(1)) || push) ? ST_WRITE : ST_IDLE;
                end
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wait_cnt      <= '0;
            rsp_accepted  <= 1'b0;
            rsp_shape     <= '0;
            rsp_operation <= '0;
        end else begin
            state <= state_next;
            if (state == ST_READ) begin
                wait_cnt <= WCW'(RD_LATENCY - 1);
            end else if (state == ST_WAIT && !wait_last) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == ST_WAIT && wait_last) begin
                rsp_shape     <= rd_shape;
                rsp_operation <= rd_op;
                rsp_accepted  <= (rd_shape == head.shape) && (rd_op == head.operation);
            end
        end
    end

    // Strobes decode straight from the state register, so they carry no input path.
    assign write      = (state == ST_WRITE);
    assign read       = (state == ST_READ);
    assign rsp_valid  = (state == ST_RESP);
    assign write_data = write ? pack_req(head) : '0;
    assign busy       = (state != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_shape_sfr_driver.sv
// Self-checking bench: SFR model with legality rules, scoreboard queues for write data and responses.
module tb_shape_sfr_driver;
    import shape_sfr_pkg::*;

    localparam int FIFO_DEPTH = 4;
    localparam int RD_LATENCY = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_shape = '0;
    logic [4:0]  req_operation = '0;
    logic        write;
    logic [31:0] write_data;
    logic        read;
    logic [31:0] read_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_accepted;
    logic [1:0]  rsp_shape;
    logic [4:0]  rsp_operation;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int n_wr = 0, n_rd = 0, n_rsp = 0, n_pushed = 0;

    logic [7:0]  rsp_q[$];
    logic [31:0] wd_q[$];
    logic [6:0]  sfr = 7'b01_00000;
    logic [6:0]  ref_sfr = 7'b01_00000;

    shape_sfr_driver #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_shape     (req_shape),
        .req_operation (req_operation),
        .write         (write),
        .write_data    (write_data),
        .read          (read),
        .read_data     (read_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_accepted  (rsp_accepted),
        .rsp_shape     (rsp_shape),
        .rsp_operation (rsp_operation),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // SFR behaviour: shape 11 drops the whole write, shape 00 applies only the operation.
    function automatic logic [6:0] sfr_next(input logic [6:0] cur, input shape_t s, input operation_t o);
        if (s == 2'b11) return cur;
        if (s == 2'b00) return {cur[6:5], o};
        return {s, o};
    endfunction

    always @(posedge clk) begin
        if (write) sfr <= sfr_next(sfr, write_data[17:16], write_data[4:0]);
        if (read)  read_data <= ($urandom() & ~32'h0003_001F) | {14'b0, sfr[6:5], 11'b0, sfr[4:0]};
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (write && read) chk("wr_rd_overlap", 1, 0);
            if (read) n_rd++;
            if (write) begin
                n_wr++;
                if (wd_q.size() == 0) chk("write_unexpected", 1, 0);
                else chk("write_data", write_data, wd_q.pop_front());
            end
            if (rsp_valid && rsp_ready) begin
                n_rsp++;
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_fields", {24'b0, rsp_accepted, rsp_shape, rsp_operation}, {24'b0, rsp_q.pop_front()});
            end
        end
    end

    task automatic push_req(input shape_t s, input operation_t o);
        int budget;
        logic [6:0] nxt;
        budget = 300;
        @(posedge clk); #1;
        req_valid = 1'b1; req_shape = s; req_operation = o;
        @(negedge clk);
        while (!req_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (!req_ready) begin
            chk("push_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        nxt = sfr_next(ref_sfr, s, o);
        rsp_q.push_back({(nxt == {s, o}), nxt});
        wd_q.push_back({14'b0, s, 11'b0, o});
        ref_sfr = nxt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_pushed++;
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 300;
        @(negedge clk);
        while ((rsp_q.size() != 0 || busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk(tag, {31'b0, (rsp_q.size() == 0 && !busy)}, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_write"}, {31'b0, write}, 0);
        chk({tag, "_read"}, {31'b0, read}, 0);
        chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 0);
        chk({tag, "_rsp_accepted"}, {31'b0, rsp_accepted}, 0);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_write_data"}, write_data, 0);
        chk({tag, "_rsp_fields"}, {25'b0, rsp_shape, rsp_operation}, 0);
        chk({tag, "_req_ready"}, {31'b0, req_ready}, 1);
    endtask

    initial begin
        int base_wr, base_rd, base_rsp, budget;

        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Legal request with exact latency checks.
        push_req(2'b01, 5'b00001);
        @(negedge clk);
        chk("lat_write", {31'b0, write}, 1);
        chk("lat_wdata", write_data, 32'h0001_0001);
        @(negedge clk);
        chk("lat_read", {31'b0, read}, 1);
        @(negedge clk);
        chk("lat_no_rsp_yet", {31'b0, rsp_valid}, 0);
        @(negedge clk);
        chk("lat_rsp", {31'b0, rsp_valid}, 1);
        wait_drain("drain_legal");

        push_req(2'b11, 5'b00000);
        wait_drain("drain_illegal");
        push_req(2'b00, 5'b00000);
        wait_drain("drain_partial");

        // Backpressure: responses stall, FIFO fills, then everything drains in order.
        base_rsp = n_rsp;
        base_wr  = n_pushed;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    push_req(shape_t'($urandom_range(0, 3)), operation_t'($urandom_range(0, 31)));
            end
        join_none
        repeat (40) @(negedge clk);
        chk("bp_req_ready_low", {31'b0, req_ready}, 0);
        chk("bp_rsp_held", {31'b0, rsp_valid}, 1);
        chk("bp_buffered", n_pushed - base_wr, FIFO_DEPTH);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        budget = 400;
        while ((n_pushed - base_wr < 6 || rsp_q.size() != 0 || busy) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("bp_drained", {31'b0, (budget > 0)}, 1);
        chk("bp_rsp_count", n_rsp - base_rsp, 6);

        // Reset in WAIT: the aborted request must never answer.
        push_req(2'b10, 5'b00101);
        budget = 20;
        @(negedge clk);
        while (!read && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        chk("abort_saw_read", {31'b0, read}, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        rsp_q.delete();
        wd_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base_wr = n_wr; base_rd = n_rd; base_rsp = n_rsp;
        repeat (10) @(negedge clk);
        chk("post_rst_no_write", n_wr - base_wr, 0);
        chk("post_rst_no_read", n_rd - base_rd, 0);
        chk("post_rst_no_rsp", n_rsp - base_rsp, 0);
        chk("post_rst_busy", {31'b0, busy}, 0);
        chk("post_rst_req_ready", {31'b0, req_ready}, 1);

        push_req(2'b10, 5'b01010);
        wait_drain("drain_recover");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        chk("global_timeout", 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
